// File: rtl/bhq_pkg.sv
// bhq_pkg: shared types, default sizes and the occupancy test for the branch history queue.
package bhq_pkg;

    localparam int BHQ_DEPTH     = 8;
    localparam int BHQ_TAG_W     = $clog2(BHQ_DEPTH);
    localparam int BHQ_GBHR_SIZE = 7;

    typedef struct packed {
        logic [31:0]              pc;
        logic                     pred;
        logic [BHQ_GBHR_SIZE-1:0] ghr;
        logic                     resolved;
        logic                     taken;
    } bhq_entry_t;

    // A tag is occupied when its distance from the head is below the occupancy.
    function automatic logic in_range(
        input logic [BHQ_TAG_W:0]   head,
        input logic [BHQ_TAG_W:0]   tail,
        input logic [BHQ_TAG_W-1:0] tag
    );
        logic [BHQ_TAG_W:0]   cnt;
        logic [BHQ_TAG_W-1:0] off;
        cnt = tail - head;
        off = tag - head[BHQ_TAG_W-1:0];
        return {1'b0, off} < cnt;
    endfunction

endpackage

// File: rtl/bhq_ptr_ctrl.sv
// bhq_ptr_ctrl: head/tail pointers with wrap bits, occupancy flags and flush truncation.
module bhq_ptr_ctrl
    import bhq_pkg::*;
#(
    parameter int TAG_W = BHQ_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alloc,
    input  logic             i_retire,
    input  logic             i_flush,
    input  logic [TAG_W-1:0] i_flush_tag,
    output logic [TAG_W:0]   o_head,
    output logic [TAG_W:0]   o_tail,
    output logic [TAG_W:0]   o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [TAG_W:0]   r_head, r_tail;
    logic [TAG_W-1:0] w_flush_off;
    logic [TAG_W:0]   w_flush_tail;

    // Truncation is measured from the pre-retire head so the head entry always survives.
    assign w_flush_off  = i_flush_tag - r_head[TAG_W-1:0];
    assign w_flush_tail = r_head + {1'b0, w_flush_off} + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (i_retire) r_head <= r_head + 1'b1;
            if (i_flush) r_tail <= w_flush_tail;
            else if (i_alloc) r_tail <= r_tail + 1'b1;
        end
    end

    assign o_head  = r_head;
    assign o_tail  = r_tail;
    assign o_count = r_tail - r_head;
    assign o_empty = r_head == r_tail;
    assign o_full  = (r_head[TAG_W-1:0] == r_tail[TAG_W-1:0]) && (r_head[TAG_W] != r_tail[TAG_W]);

endmodule

// File: rtl/branch_history_queue.sv
// branch_history_queue: tracks predicted branches, accepts out-of-order resolution and
// retires in program order, emitting one predictor update per retired branch.
module branch_history_queue
    import bhq_pkg::*;
#(
    parameter int DEPTH     = BHQ_DEPTH,
    parameter int TAG_W     = BHQ_TAG_W,
    parameter int GBHR_SIZE = BHQ_GBHR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    input  logic [31:0]          alloc_pc,
    input  logic                 alloc_pred_taken,
    input  logic [GBHR_SIZE-1:0] alloc_ghr,
    output logic                 alloc_ready,
    output logic [TAG_W-1:0]     alloc_tag,
    input  logic                 resolve_valid,
    input  logic [TAG_W-1:0]     resolve_tag,
    input  logic                 resolve_taken,
    input  logic                 flush_valid,
    input  logic [TAG_W-1:0]     flush_tag,
    output logic                 mispredict_valid,
    output logic [TAG_W-1:0]     mispredict_tag,
    output logic                 update_en,
    output logic [31:0]          update_pc,
    output logic                 actual_taken,
    output logic [GBHR_SIZE-1:0] update_ghr,
    output logic [TAG_W:0]       count
);

    logic [TAG_W:0]   w_head, w_tail;
    logic             w_full, w_empty;
    logic [TAG_W-1:0] w_head_idx, w_tail_idx, w_res_off, w_flush_off;
    logic             w_alloc, w_retire, w_res_hit;
    bhq_entry_t       r_mem [DEPTH];

    bhq_ptr_ctrl #(.TAG_W(TAG_W)) u_ptr (
        .clk        (clk),
        .rst        (rst),
        .i_alloc    (w_alloc),
        .i_retire   (w_retire),
        .i_flush    (flush_valid),
        .i_flush_tag(flush_tag),
        .o_head     (w_head),
        .o_tail     (w_tail),
        .o_count    (count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign w_head_idx  = w_head[TAG_W-1:0];
    assign w_tail_idx  = w_tail[TAG_W-1:0];
    assign w_res_off   = resolve_tag - w_head_idx;
    assign w_flush_off = flush_tag - w_head_idx;
    assign alloc_ready = !w_full;
    assign alloc_tag   = w_tail_idx;
    assign w_alloc     = alloc_valid && alloc_ready && !flush_valid;
    assign w_retire    = !w_empty && r_mem[w_head_idx].resolved;
    // A resolve aimed at an entry squashed by the same-cycle flush is dropped entirely.
    assign w_res_hit   = resolve_valid && in_range(w_head, w_tail, resolve_tag)
                         && (!flush_valid || w_res_off <= w_flush_off);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i].resolved <= 1'b0;
        end else begin
            if (w_alloc) r_mem[w_tail_idx] <= '{pc: alloc_pc, pred: alloc_pred_taken, ghr: alloc_ghr,
                                                resolved: 1'b0, taken: 1'b0};
            if (w_res_hit) begin
                r_mem[resolve_tag].resolved <= 1'b1;
                r_mem[resolve_tag].taken    <= resolve_taken;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_valid <= 1'b0;
            mispredict_tag   <= '0;
            update_en        <= 1'b0;
            update_pc        <= '0;
            actual_taken     <= 1'b0;
            update_ghr       <= '0;
        end else begin
            mispredict_valid <= w_res_hit && (resolve_taken != r_mem[resolve_tag].pred);
            if (w_res_hit && (resolve_taken != r_mem[resolve_tag].pred)) mispredict_tag <= resolve_tag;
            update_en <= w_retire;
            if (w_retire) begin
                update_pc    <= r_mem[w_head_idx].pc;
                actual_taken <= r_mem[w_head_idx].taken;
                update_ghr   <= r_mem[w_head_idx].ghr;
            end
        end
    end

    a_flush_occupied: assert property (@(posedge clk) disable iff (rst)
        flush_valid |-> in_range(w_head, w_tail, flush_tag));

endmodule

// File: tb/tb_branch_history_queue.sv
// tb_branch_history_queue: queue-based reference model checked every cycle, plus directed literal checks.
module tb_branch_history_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [31:0] alloc_pc = '0;
    logic        alloc_pred_taken = 1'b0;
    logic [6:0]  alloc_ghr = '0;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        resolve_valid = 1'b0;
    logic [2:0]  resolve_tag = '0;
    logic        resolve_taken = 1'b0;
    logic        flush_valid = 1'b0;
    logic [2:0]  flush_tag = '0;
    logic        mispredict_valid;
    logic [2:0]  mispredict_tag;
    logic        update_en;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic [6:0]  update_ghr;
    logic [3:0]  count;

    int tests = 0;
    int fails = 0;

    branch_history_queue dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred_taken(alloc_pred_taken),
        .alloc_ghr(alloc_ghr), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .mispredict_valid(mispredict_valid), .mispredict_tag(mispredict_tag),
        .update_en(update_en), .update_pc(update_pc), .actual_taken(actual_taken),
        .update_ghr(update_ghr), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%h exp=%h", n, $time, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [6:0]  ghr;
        logic        res;
        logic        tk;
        int          tag;
    } ment_t;

    ment_t       mq[$];
    int          m_next = 0;
    logic        e_upd, e_tk, e_mis;
    logic [31:0] e_pc;
    logic [6:0]  e_ghr;
    logic [2:0]  e_mtag;

    // Reference: program-ordered list of live branches, searched by tag.
    always @(posedge clk) begin
        int  ri, fi;
        bit  ret, hit;
        if (rst) begin
            mq.delete();
            m_next = 0;
            e_upd = 0; e_pc = 0; e_tk = 0; e_ghr = 0; e_mis = 0; e_mtag = 0;
        end else begin
            ret = mq.size() > 0 && mq[0].res;
            ri = -1;
            fi = -1;
            foreach (mq[i]) begin
                if (mq[i].tag == int'(resolve_tag)) ri = i;
                if (mq[i].tag == int'(flush_tag)) fi = i;
            end
            hit = resolve_valid && ri >= 0 && (!flush_valid || ri <= fi);
            e_mis = 0;
            if (hit) e_mis = mq[ri].pred != resolve_taken;
            if (e_mis) e_mtag = resolve_tag;
            e_upd = ret;
            if (ret) begin
                e_pc = mq[0].pc;
                e_tk = mq[0].tk;
                e_ghr = mq[0].ghr;
            end
            if (hit) begin
                mq[ri].res = 1;
                mq[ri].tk = resolve_taken;
            end
            if (flush_valid && fi >= 0) begin
                while (mq.size() > fi + 1) void'(mq.pop_back());
                m_next = (mq[fi].tag + 1) % 8;
            end else if (!flush_valid && alloc_valid && mq.size() < 8) begin
                mq.push_back('{pc: alloc_pc, pred: alloc_pred_taken, ghr: alloc_ghr, res: 0, tk: 0, tag: m_next});
                m_next = (m_next + 1) % 8;
            end
            if (ret) void'(mq.pop_front());
        end
        #1;
        chk("update_en", update_en, e_upd);
        chk("update_pc", update_pc, e_pc);
        chk("actual_taken", actual_taken, e_tk);
        chk("update_ghr", update_ghr, e_ghr);
        chk("mispredict_valid", mispredict_valid, e_mis);
        chk("mispredict_tag", mispredict_tag, e_mtag);
        chk("count", count, mq.size());
        chk("alloc_ready", alloc_ready, mq.size() < 8);
        chk("alloc_tag", alloc_tag, m_next);
    end

    task automatic cyc();
        @(negedge clk);
        rst = 0;
        alloc_valid = 0;
        resolve_valid = 0;
        flush_valid = 0;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic pred, input logic [6:0] ghr);
        alloc_valid = 1;
        alloc_pc = pc;
        alloc_pred_taken = pred;
        alloc_ghr = ghr;
    endtask

    task automatic set_res(input int tag, input logic tk);
        resolve_valid = 1;
        resolve_tag = 3'(tag);
        resolve_taken = tk;
    endtask

    task automatic do_reset();
        rst = 1;
        cyc();
    endtask

    initial begin
        cyc();
        do_reset();
        chk("lit_reset_count", count, 0);
        chk("lit_reset_upd", update_en, 0);
        chk("lit_reset_ready", alloc_ready, 1);

        // In-order retirement of three branches resolved in reverse order
        set_alloc(32'h100, 1, 7'h05); cyc();
        set_alloc(32'h104, 0, 7'h0B); cyc();
        set_alloc(32'h108, 1, 7'h17); cyc();
        chk("lit_count3", count, 3);
        chk("lit_tag3", alloc_tag, 3);
        set_res(2, 1); cyc();
        set_res(1, 0); cyc();
        set_res(0, 1); cyc();
        chk("lit_upd_wait", update_en, 0);
        cyc();
        chk("lit_upd0", update_en, 1);
        chk("lit_pc0", update_pc, 32'h100);
        chk("lit_ghr0", update_ghr, 7'h05);
        cyc();
        chk("lit_pc1", update_pc, 32'h104);
        chk("lit_tk1", actual_taken, 0);
        cyc();
        chk("lit_pc2", update_pc, 32'h108);
        chk("lit_ghr2", update_ghr, 7'h17);
        cyc();
        chk("lit_upd_done", update_en, 0);

        // Mispredict
        do_reset();
        set_alloc(32'h200, 1, 7'h11); cyc();
        set_res(0, 0); cyc();
        chk("lit_mis", mispredict_valid, 1);
        chk("lit_mis_tag", mispredict_tag, 0);
        cyc();
        chk("lit_mis_off", mispredict_valid, 0);
        chk("lit_mis_upd", update_en, 1);
        chk("lit_mis_tk", actual_taken, 0);
        cyc();

        // Full queue
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_alloc(32'h300 + 32'(4 * i), 0, 7'(i));
            cyc();
        end
        chk("lit_full_ready", alloc_ready, 0);
        chk("lit_full_count", count, 8);
        set_alloc(32'h400, 1, 7'h7F); cyc();
        chk("lit_drop_count", count, 8);
        set_alloc(32'h400, 1, 7'h7F); set_res(0, 0); cyc();
        set_alloc(32'h400, 1, 7'h7F); cyc();
        chk("lit_pop_noalloc", count, 7);
        chk("lit_pop_pc", update_pc, 32'h300);
        chk("lit_pop_ready", alloc_ready, 1);
        set_alloc(32'h400, 1, 7'h7F); cyc();
        chk("lit_refill", count, 8);

        // Flush
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_alloc(32'h500 + 32'(4 * i), 0, 7'(i));
            cyc();
        end
        flush_valid = 1; flush_tag = 2; set_alloc(32'h600, 0, 0); cyc();
        chk("lit_flush_count", count, 3);
        chk("lit_flush_tag", alloc_tag, 3);
        set_res(4, 1); cyc();
        chk("lit_squashed_mis", mispredict_valid, 0);
        cyc();
        chk("lit_squashed_upd", update_en, 0);
        chk("lit_squashed_count", count, 3);
        set_alloc(32'h700, 0, 1); cyc();
        set_alloc(32'h704, 0, 2); cyc();
        flush_valid = 1; flush_tag = 3; set_res(4, 1); cyc();
        chk("lit_flush_res_mis", mispredict_valid, 0);
        chk("lit_flush_res_count", count, 4);
        set_res(0, 0); cyc();
        flush_valid = 1; flush_tag = 0; cyc();
        chk("lit_flush_retire_upd", update_en, 1);
        chk("lit_flush_retire_count", count, 0);
        cyc();

        // Wrap-around
        do_reset();
        for (int k = 0; k < 20; k++) begin
            chk("lit_wrap_tag", alloc_tag, k % 8);
            set_alloc(32'h1000 + 32'(4 * k), k[0], 7'(k));
            cyc();
            set_res(k % 8, k[1]); cyc();
            cyc();
            chk("lit_wrap_upd", update_en, 1);
            chk("lit_wrap_pc", update_pc, 32'h1000 + 32'(4 * k));
        end

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc(32'h800 + 32'(4 * i), 1, 7'(i));
            cyc();
        end
        set_res(1, 0); cyc();
        set_res(3, 1); cyc();
        rst = 1; cyc();
        chk("lit_rst_count", count, 0);
        chk("lit_rst_upd", update_en, 0);
        chk("lit_rst_mis", mispredict_valid, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("lit_rst_stale", update_en, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_history_queue.md
Name: branch_history_queue

Overview:
- Sits between fetch/predict and branch resolution. It is the producer of the branch predictor's update interface (update_en / update_pc / actual_taken).
- At predict time, each predicted branch is allocated an entry holding its PC, prediction and GBHR snapshot.
- Branches resolve out of order from the superscalar execute units. Entries retire in program order, and each retirement drives exactly one predictor update carrying the correct history snapshot.
- Also reports mispredictions and supports squash of younger entries on a pipeline flush.

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of two, ≥2.
- TAG_W, 3, log2(DEPTH); width of an entry tag.
- GBHR_SIZE, 7, width of the stored global-history snapshot; matches the predictor.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- alloc_valid  in  1  allocate a new entry this cycle.
- alloc_pc  in  32  PC of the predicted branch.
- alloc_pred_taken  in  1  predictor's predict_taken for that PC.
- alloc_ghr  in  GBHR_SIZE  GBHR value used for the prediction.
- alloc_ready  out  1  queue not full (combinational from pointers).
- alloc_tag  out  TAG_W  tag the entry receives if allocated now (= tail index).
- resolve_valid  in  1  a branch resolved this cycle.
- resolve_tag  in  TAG_W  tag of the resolved branch.
- resolve_taken  in  1  actual direction.
- flush_valid  in  1  squash all entries younger than flush_tag.
- flush_tag  in  TAG_W  youngest surviving entry.
- mispredict_valid  out  1  registered one-cycle pulse.
- mispredict_tag  out  TAG_W  tag of the mispredicted branch.
- update_en  out  1  registered one-cycle pulse to the predictor.
- update_pc  out  32  PC of the retiring branch.
- actual_taken  out  1  resolved direction of the retiring branch.
- update_ghr  out  GBHR_SIZE  GBHR snapshot of the retiring branch.
- count  out  TAG_W+1  number of occupied entries.

Behaviour:
- Storage and pointers:
  - Circular buffer with head and tail pointers of TAG_W+1 bits each; the extra MSB is the wrap bit.
  - count = tail − head. Empty when head == tail. Full when the index bits are equal and the wrap bits differ.
  - Per entry: pc, pred, ghr, resolved, taken.
- Reset (synchronous, rst high at an edge):
  - head = tail = 0; all resolved bits = 0.
  - update_en = 0, mispredict_valid = 0; update_pc, actual_taken, update_ghr and mispredict_tag = 0.
  - Reset overrides every other input in that cycle.
- Allocate:
  - Happens when alloc_valid && alloc_ready && !flush_valid.
  - Writes the entry at the tail index, clears its resolved bit, and increments tail.
  - alloc_ready is computed from the current count only. A pop in the same cycle does not free space, so a full queue refuses allocation even while popping.
  - If alloc_valid is high while the queue is full, the allocation is dropped silently; the upstream stage must hold.
- Resolve:
  - On resolve_valid, if resolve_tag lies in [head, tail) (modular), set resolved = 1 and taken = resolve_taken.
  - A resolve to an unoccupied tag is ignored.
  - If taken != pred, then at the same edge register mispredict_valid = 1 and mispredict_tag = resolve_tag.
  - Otherwise mispredict_valid = 0 next cycle.
- Retire:
  - Each edge, if the queue is non-empty and the head entry's resolved bit is 1: register update_en = 1 together with update_pc, actual_taken and update_ghr from that entry, then increment head.
  - Otherwise update_en = 0; the data outputs hold their last values.
  - At most one retirement per cycle.
  - Latency: resolve_valid presented at edge E0 produces update_en high in the cycle after E1, i.e. 2 cycles after the resolve when the entry is at the head.
- Flush:
  - On flush_valid, set tail = head + ((flush_tag − head[TAG_W-1:0]) mod DEPTH) + 1, keeping the wrap bit consistent.
  - The entry flush_tag survives; all entries younger than it are discarded.
  - flush_tag must be occupied, otherwise behaviour is undefined (checked by assertion).
- Simultaneous events:
  - flush and alloc: flush wins; the alloc is dropped.
  - flush and resolve of a squashed tag: the resolve is ignored, and no mispredict is reported for it.
  - flush and retire of the head: the retire proceeds. The new tail is computed with the pre-retire head, so the head entry is never squashed.
  - resolve and retire on different tags: both occur.
  - A resolve of the current head becomes visible for retirement at the next edge only.
- Wrap-around: all index arithmetic is modulo DEPTH; the wrap bit toggles whenever the index passes DEPTH−1.

Decomposition:
- Package bhq_pkg:
  - entry typedef {pc[31:0], pred, ghr[GBHR_SIZE-1:0], resolved, taken};
  - default DEPTH and GBHR_SIZE constants;
  - an in_range(head, tail, tag) function.
- One sub-module: bhq_ptr_ctrl, which holds the head/tail registers, full/empty/count logic and the flush tail computation. The entry array and the output registers stay in the top level.

Test Plan:
- Reset, then allocate 3 entries (pc 0x100/0x104/0x108, pred 1/0/1, ghr 0x05/0x0B/0x17), then resolve tags 2,1,0 taken 1,0,1 → no mispredict_valid. update_en pulses 3 consecutive cycles, in order 0x100/0x104/0x108, with matching actual_taken and ghr; pulses begin 2 cycles after resolve of tag 0.
- Allocate one entry with pred 1, then resolve it with taken 0 → mispredict_valid = 1 with mispredict_tag = 0 for exactly one cycle, then update_en with actual_taken = 0.
- Fill 8 entries → alloc_ready = 0 and count = 8. A 9th alloc_valid is dropped. Retire the head and hold alloc in the same cycle → still not accepted until the next cycle.
- Allocate tags 0–5, then flush_valid with flush_tag = 2 → count = 3 and alloc_tag = 3. A later resolve of tag 4 is ignored: no update and no mispredict.
- Wrap-around: run 20 alloc/resolve/retire iterations → tags cycle 0..7 and all 20 updates appear in order with correct PCs.
- Assert rst mid-stream with 4 pending and 2 resolved → the next cycle has count = 0, update_en = 0 and mispredict_valid = 0, and no stale updates appear afterwards.
